// File: rtl/pipe_credit_adapter_pkg.sv
// Shared definitions for the pipe credit adapter.
//   - default WIDTH / LATENCY / DEPTH constants
//   - credit_cnt_w(): width of a counter that must hold 0..depth inclusive
package pipe_credit_adapter_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_LATENCY = 2;
    localparam int DEFAULT_DEPTH   = 4;

    function automatic int credit_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_return_fifo.sv
// Return buffer for results coming back from the valid-only pipeline.
// Storage is a register array, so an entry written in one cycle is first
// visible on rd_data the next cycle (no write-to-read bypass).
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   wr_en, wr_data  push request; ignored when full unless a pop happens too
//   rd_en           pop request; honoured only when not empty
//   rd_data         head entry, 0 while empty
//   full, empty     occupancy flags
//   count           entries currently stored (0..DEPTH)
module pipe_return_fifo
    import pipe_credit_adapter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [WIDTH-1:0]                  wr_data,
    input  logic                              rd_en,
    output logic [WIDTH-1:0]                  rd_data,
    output logic                              full,
    output logic                              empty,
    output logic [credit_cnt_w(DEPTH)-1:0]    count
);

    localparam int CW = credit_cnt_w(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop  = rd_en && (count_q != '0);
        // When full, the tail slot is the head slot; a same-cycle pop frees it.
        do_wr   = wr_en && ((count_q != CW'(DEPTH)) || do_pop);
        head_d  = do_pop ? ptr_inc(head_q) : head_q;
        tail_d  = do_wr  ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        unique case ({do_wr, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: rd_data is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[tail_q] <= wr_data;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[head_q];

endmodule

// File: rtl/pipe_credit_adapter.sv
// Credit-based ready/valid wrapper around a fixed-latency valid-only pipeline.
// A credit is taken when an item enters the pipeline and returned when its
// result leaves the return buffer, so the buffer can never overflow in
// normal operation and upstream ready never waits on downstream ready.
//
// Ports
//   clk, rst                         clock, synchronous active-low reset
//   in_valid, in_data, in_ready      upstream handshake
//   pipe_in_valid, pipe_in_data      drive the attached pipeline input
//   pipe_out_valid, pipe_out_data    attached pipeline result
//   out_valid, out_data, out_ready   downstream handshake
//   used                             credits consumed (in flight + buffered)
//   err                              sticky protocol error
module pipe_credit_adapter
    import pipe_credit_adapter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              in_ready,
    output logic                              pipe_in_valid,
    output logic [WIDTH-1:0]                  pipe_in_data,
    input  logic                              pipe_out_valid,
    input  logic [WIDTH-1:0]                  pipe_out_data,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  out_data,
    input  logic                              out_ready,
    output logic [credit_cnt_w(DEPTH)-1:0]    used,
    output logic                              err
);

    localparam int CW = credit_cnt_w(DEPTH);

    if (DEPTH < LATENCY + 1) begin : g_depth_check
        $error("pipe_credit_adapter: DEPTH must be at least LATENCY + 1");
    end

    logic [CW-1:0] used_q, used_d;
    logic          err_q, err_d;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          no_in_flight;

    pipe_return_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe_out_valid),
        .wr_data (pipe_out_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // rst gating keeps ready low for the whole reset window, not just after
    // the first edge.
    assign in_ready      = rst && (used_q < CW'(DEPTH));
    assign accept        = in_valid && in_ready;
    assign pipe_in_valid = accept;
    assign pipe_in_data  = in_data;
    assign out_valid     = !fifo_empty;
    assign pop           = out_valid && out_ready;

    always_comb begin
        used_d = used_q;
        if (accept && !pop) begin
            used_d = used_q + CW'(1);
        end else if (pop && !accept && (used_q != '0)) begin
            // Saturate: a spurious result can be popped without ever having
            // held a credit.
            used_d = used_q - CW'(1);
        end

        // In-flight count is used minus buffered; zero or less means the
        // pipeline should have nothing to return.
        no_in_flight = (used_q <= fifo_count);
        err_d = err_q
              | (pipe_out_valid && fifo_full && !pop)
              | (pipe_out_valid && no_in_flight);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            used_q <= '0;
            err_q  <= 1'b0;
        end else begin
            used_q <= used_d;
            err_q  <= err_d;
        end
    end

    assign used = used_q;
    assign err  = err_q;

endmodule

// File: tb/tb_pipe_credit_adapter.sv
// Scoreboard bench for pipe_credit_adapter with an attached LATENCY=2
// pipeline that computes x+1.
module tb_pipe_credit_adapter;

    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int D   = 4;
    localparam int CW  = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          pipe_in_valid;
    logic [W-1:0]  pipe_in_data;
    logic          pipe_out_valid;
    logic [W-1:0]  pipe_out_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [CW-1:0] used;
    logic          err;

    logic          spur = 1'b0;
    logic [W-1:0]  spur_data = '0;

    always #5 clk = ~clk;

    pipe_credit_adapter #(.WIDTH(W), .LATENCY(LAT), .DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_in_data   (pipe_in_data),
        .pipe_out_valid (pipe_out_valid),
        .pipe_out_data  (pipe_out_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .used           (used),
        .err            (err)
    );

    // Attached pipeline: LAT register stages, result = input + 1.
    logic [LAT-1:0] p_v;
    logic [W-1:0]   p_d [LAT];
    always @(posedge clk) begin
        if (!rst) begin
            p_v <= '0;
        end else begin
            p_v[0] <= pipe_in_valid;
            p_d[0] <= pipe_in_data + 32'd1;
            for (int i = 1; i < LAT; i++) begin
                p_v[i] <= p_v[i-1];
                p_d[i] <= p_d[i-1];
            end
        end
    end
    assign pipe_out_valid = p_v[LAT-1] | spur;
    assign pipe_out_data  = spur ? spur_data : p_d[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state
    typedef struct {
        logic [W-1:0] data;
        int           acc_cyc;
    } exp_t;
    exp_t         exp_q[$];
    logic [W-1:0] got_q[$];
    int           m_used = 0;
    bit           chk_en = 1'b1;
    bit           held = 1'b0;
    logic [W-1:0] held_data = '0;
    int           acc_cnt = 0;

    // Monitor: reference is "accepted minus delivered" credits and an
    // in-order queue of in_data+1 for every accepted item.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            m_used = 0;
            held   = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cnt++;
            if (chk_en) begin
                check("used", 32'(used), 32'(m_used));
                check("in_ready", 32'(in_ready), 32'(m_used < D));
                check("err_clear", 32'(err), 32'd0);
                if (held && out_valid) check("hold_data", out_data, held_data);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got 0x%0h with nothing expected (cycle %0d)", out_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("latency_min", 32'((cyc - e.acc_cyc) >= LAT + 1), 32'd1);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back('{data: in_data + 32'd1, acc_cyc: cyc});
                end
                m_used += int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end else if (out_valid && out_ready) begin
                got_q.push_back(out_data);
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        spur = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_used != 0) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size() == 0 && m_used == 0), 32'd1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        int idx;
        int a0;
        int n;
        int bubbles;
        int seen;
        logic [W-1:0] exp_seq [5];

        // Reset values, with in_valid held high to show gating.
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1234;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_pipe_in_valid", 32'(pipe_in_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_used", 32'(used), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;

        // Single item in the very first cycle out of reset.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h0000_0005;
        start = cyc;
        tick();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check("single_latency", 32'(cyc - start), 32'd3);
        check("single_data", out_data, 32'h0000_0006);
        tick();
        drain("single");

        // Backpressure: stream 0..9 with out_ready low.
        out_ready = 1'b0;
        idx = 0;
        a0 = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = 32'(idx);
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        check("bp_accepts", 32'(acc_cnt - a0), 32'd4);
        @(negedge clk);
        check("bp_used", 32'(used), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_err", 32'(err), 32'd0);
        tick();
        out_ready = 1'b1;
        n = 0;
        while (idx < 10 && n < 100) begin
            in_valid = 1'b1;
            in_data = 32'(idx);
            @(negedge clk);
            if (in_ready) idx++;
            tick();
            n++;
        end
        check("bp_all_sent", 32'(idx), 32'd10);
        drain("bp");

        // Full throughput: 100 back-to-back items.
        out_ready = 1'b1;
        a0 = acc_cnt;
        bubbles = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = $urandom;
            @(negedge clk);
            if (!in_ready) bubbles++;
            tick();
        end
        in_valid = 1'b0;
        check("tp_bubbles", 32'(bubbles), 32'd0);
        check("tp_accepts", 32'(acc_cnt - a0), 32'd100);
        check("tp_err", 32'(err), 32'd0);
        drain("tp");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain("rand");

        // Reset with two items in flight; nothing stale may emerge.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check("mid_rst_used", 32'(used), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
        check("mid_rst_no_stale", 32'(seen), 32'd0);

        // Spurious pipe_out_valid with no credits used.
        do_reset();
        chk_en = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("spur_err_before", 32'(err), 32'd0);
        tick();
        spur = 1'b1;
        spur_data = 32'hDEAD;
        tick();
        spur = 1'b0;
        @(negedge clk);
        check("spur_err_set", 32'(err), 32'd1);
        check("spur_used", 32'(used), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        check("spur_err_sticky", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        check("spur_err_cleared", 32'(err), 32'd0);

        // Write and pop together while the return buffer is full.
        got_q.delete();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        check("full_used", 32'(used), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", out_data, 32'd1);
        tick();
        spur = 1'b1;
        spur_data = 32'h77;
        out_ready = 1'b1;
        tick();
        spur = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        exp_seq[0] = 32'd1;
        exp_seq[1] = 32'd2;
        exp_seq[2] = 32'd3;
        exp_seq[3] = 32'd4;
        exp_seq[4] = 32'h77;
        check("full_pushpop_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check("full_pushpop_data", got_q[i], exp_seq[i]);
        end
        check("full_pushpop_err", 32'(err), 32'd1);
        do_reset();
        chk_en = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
